// File: rtl/midi_msg_parser_pkg.sv
// Shared MIDI constants: command codes, status nibbles, parser states and
// the status-to-command decode used by the MIDI message parser.
package midi_msg_parser_pkg;

  localparam int MIDI_CMD_SIZE = 3;

  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF = 3'd0;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON  = 3'd1;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_POLY_AT  = 3'd2;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC       = 3'd3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PROG     = 3'd4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CH_AT    = 3'd5;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH    = 3'd6;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NONE     = 3'd7;

  localparam logic [3:0] STAT_NOTE_OFF = 4'h8;
  localparam logic [3:0] STAT_NOTE_ON  = 4'h9;
  localparam logic [3:0] STAT_POLY_AT  = 4'hA;
  localparam logic [3:0] STAT_CC       = 4'hB;
  localparam logic [3:0] STAT_PROG     = 4'hC;
  localparam logic [3:0] STAT_CH_AT    = 4'hD;
  localparam logic [3:0] STAT_PITCH    = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D0 = 2'd1,
    ST_WAIT_D1 = 2'd2,
    ST_SKIP    = 2'd3
  } state_t;

  function automatic logic [MIDI_CMD_SIZE-1:0] status_to_cmd(input logic [3:0] nib);
    case (nib)
      STAT_NOTE_OFF: status_to_cmd = MIDI_CMD_NOTE_OFF;
      STAT_NOTE_ON:  status_to_cmd = MIDI_CMD_NOTE_ON;
      STAT_POLY_AT:  status_to_cmd = MIDI_CMD_POLY_AT;
      STAT_CC:       status_to_cmd = MIDI_CMD_CC;
      STAT_PROG:     status_to_cmd = MIDI_CMD_PROG;
      STAT_CH_AT:    status_to_cmd = MIDI_CMD_CH_AT;
      STAT_PITCH:    status_to_cmd = MIDI_CMD_PITCH;
      default:       status_to_cmd = MIDI_CMD_NONE;
    endcase
  endfunction

  function automatic logic cmd_two_data(input logic [MIDI_CMD_SIZE-1:0] cmd);
    case (cmd)
      MIDI_CMD_PROG,
      MIDI_CMD_CH_AT: cmd_two_data = 1'b0;
      default:        cmd_two_data = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte stream to parallel command bus: running status, realtime
// pass-over, SysEx skipping, channel filtering and protocol-error strobes.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter bit         OMNI        = 1'b1,
  parameter logic [3:0] CHANNEL     = 4'd0,
  parameter bit         VEL0_IS_OFF = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     byte_rdy,
  input  logic [7:0]               byte_data,
  output logic                     midi_rdy,
  output logic [MIDI_CMD_SIZE-1:0] midi_cmd,
  output logic [3:0]               midi_ch_sysn,
  output logic [6:0]               midi_data0,
  output logic [6:0]               midi_data1,
  output logic                     parse_err
);

  state_t                   state_q, state_d;
  logic [MIDI_CMD_SIZE-1:0] run_cmd_q, run_cmd_d;
  logic [3:0]               run_ch_q, run_ch_d;
  logic                     fresh_q, fresh_d;
  logic [6:0]               d0_q, d0_d;
  logic                     rdy_q, rdy_d;
  logic                     err_q, err_d;
  logic [MIDI_CMD_SIZE-1:0] cmd_q, cmd_d;
  logic [3:0]               ch_q, ch_d;
  logic [6:0]               data0_q, data0_d;
  logic [6:0]               data1_q, data1_d;

  logic                     is_rt_s, is_sys_s, is_cv_s;
  logic                     emit_s, accept_s;
  logic [6:0]               emit_d0_s, emit_d1_s;
  logic [MIDI_CMD_SIZE-1:0] emit_cmd_s;

  assign is_rt_s  = byte_data[7] & (byte_data[6:3] == 4'hF);
  assign is_sys_s = byte_data[7] & (byte_data[6:3] == 4'hE);
  assign is_cv_s  = byte_data[7] & ~is_rt_s & ~is_sys_s;
  assign accept_s = OMNI | (run_ch_q == CHANNEL);

  // Next-state, running status and output bus computation.
  always_comb begin
    state_d   = state_q;
    run_cmd_d = run_cmd_q;
    run_ch_d  = run_ch_q;
    fresh_d   = fresh_q;
    d0_d      = d0_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
    cmd_d     = cmd_q;
    ch_d      = ch_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    emit_s    = 1'b0;
    emit_d0_s = 7'd0;
    emit_d1_s = 7'd0;

    if (!byte_rdy || is_rt_s) begin
      state_d = state_q;
    end else if (is_cv_s) begin
      // A new status abandons any message that has started but not finished.
      err_d     = (state_q == ST_WAIT_D1) | ((state_q == ST_WAIT_D0) & fresh_q);
      run_cmd_d = status_to_cmd(byte_data[7:4]);
      run_ch_d  = byte_data[3:0];
      fresh_d   = 1'b1;
      state_d   = ST_WAIT_D0;
    end else if (is_sys_s) begin
      fresh_d = 1'b0;
      state_d = (byte_data[3:0] == 4'h7) ? ST_IDLE : ST_SKIP;
    end else begin
      case (state_q)
        ST_IDLE: err_d = 1'b1;
        ST_WAIT_D0: begin
          if (cmd_two_data(run_cmd_q)) begin
            d0_d    = byte_data[6:0];
            state_d = ST_WAIT_D1;
          end else begin
            emit_s    = 1'b1;
            emit_d0_s = byte_data[6:0];
            fresh_d   = 1'b0;
          end
        end
        ST_WAIT_D1: begin
          emit_s    = 1'b1;
          emit_d0_s = d0_q;
          emit_d1_s = byte_data[6:0];
          fresh_d   = 1'b0;
          state_d   = ST_WAIT_D0;
        end
        default: state_d = state_q;
      endcase
    end

    if (VEL0_IS_OFF && (run_cmd_q == MIDI_CMD_NOTE_ON) && (emit_d1_s == 7'd0)) begin
      emit_cmd_s = MIDI_CMD_NOTE_OFF;
    end else begin
      emit_cmd_s = run_cmd_q;
    end

    if (emit_s && accept_s) begin
      rdy_d   = 1'b1;
      cmd_d   = emit_cmd_s;
      ch_d    = run_ch_q;
      data0_d = emit_d0_s;
      data1_d = emit_d1_s;
    end else begin
      rdy_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      run_cmd_q <= MIDI_CMD_NONE;
      run_ch_q  <= 4'd0;
      fresh_q   <= 1'b0;
      d0_q      <= 7'd0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      cmd_q     <= 3'd0;
      ch_q      <= 4'd0;
      data0_q   <= 7'd0;
      data1_q   <= 7'd0;
    end else begin
      state_q   <= state_d;
      run_cmd_q <= run_cmd_d;
      run_ch_q  <= run_ch_d;
      fresh_q   <= fresh_d;
      d0_q      <= d0_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
      ch_q      <= ch_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
    end
  end

  assign midi_rdy     = rdy_q;
  assign parse_err    = err_q;
  assign midi_cmd     = cmd_q;
  assign midi_ch_sysn = ch_q;
  assign midi_data0   = data0_q;
  assign midi_data1   = data1_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Drives an omni parser and a channel-1-only parser with directed and random
// MIDI streams and compares both buses against a message-level model.
module tb_midi_msg_parser;
  import midi_msg_parser_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic byte_rdy;
  logic [7:0] byte_data;

  logic                     rdy_o [2];
  logic [MIDI_CMD_SIZE-1:0] cmd_o [2];
  logic [3:0]               ch_o  [2];
  logic [6:0]               d0_o  [2];
  logic [6:0]               d1_o  [2];
  logic                     err_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0), .VEL0_IS_OFF(1'b1)) u_omni (
    .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .byte_data(byte_data),
    .midi_rdy(rdy_o[0]), .midi_cmd(cmd_o[0]), .midi_ch_sysn(ch_o[0]),
    .midi_data0(d0_o[0]), .midi_data1(d1_o[0]), .parse_err(err_o[0]));

  midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd1), .VEL0_IS_OFF(1'b1)) u_ch1 (
    .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .byte_data(byte_data),
    .midi_rdy(rdy_o[1]), .midi_cmd(cmd_o[1]), .midi_ch_sysn(ch_o[1]),
    .midi_data0(d0_o[1]), .midi_data1(d1_o[1]), .parse_err(err_o[1]));

  // Message-level reference: running status byte, collected data bytes, skip flag.
  bit         rs_valid;
  logic [7:0] rs;
  bit         fresh;
  bit         skipping;
  logic [6:0] got[$];
  bit         exp_rdy [2];
  bit         exp_err;
  logic [2:0] exp_cmd [2];
  logic [3:0] exp_ch  [2];
  logic [6:0] exp_d0  [2];
  logic [6:0] exp_d1  [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rs_valid = 1'b0; rs = 8'h00; fresh = 1'b0; skipping = 1'b0;
    got.delete();
    exp_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_rdy[i] = 1'b0; exp_cmd[i] = 3'd0; exp_ch[i] = 4'd0;
      exp_d0[i] = 7'd0; exp_d1[i] = 7'd0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need;
    logic [2:0] cmd;
    logic [6:0] v0, v1;
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0; exp_err = 1'b0;
    need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
    if (b >= 8'hF8) begin
      // realtime: no effect at all
    end else if (b >= 8'h80 && b < 8'hF0) begin
      exp_err = rs_valid && (got.size() > 0 || fresh);
      rs = b; rs_valid = 1'b1; fresh = 1'b1; skipping = 1'b0;
      got.delete();
    end else if (b >= 8'hF0) begin
      rs_valid = 1'b0; fresh = 1'b0; skipping = (b != 8'hF7);
      got.delete();
    end else if (skipping) begin
      // data inside SysEx / system common payload
    end else if (!rs_valid) begin
      exp_err = 1'b1;
    end else begin
      got.push_back(b[6:0]);
      if (got.size() == need) begin
        cmd = 3'(rs[7:4] - 4'd8);
        v0 = got[0];
        v1 = (need == 2) ? got[1] : 7'd0;
        if (cmd == MIDI_CMD_NOTE_ON && v1 == 7'd0) cmd = MIDI_CMD_NOTE_OFF;
        for (int i = 0; i < 2; i++) begin
          if (i == 0 || rs[3:0] == 4'd1) begin
            exp_rdy[i] = 1'b1; exp_cmd[i] = cmd; exp_ch[i] = rs[3:0];
            exp_d0[i] = v0; exp_d1[i] = v1;
          end
        end
        got.delete();
        fresh = 1'b0;
      end
    end
  endtask

  task automatic check_bus(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, i == 0 ? "/omni rdy" : "/ch1 rdy"}, {7'd0, rdy_o[i]}, {7'd0, exp_rdy[i]});
      chk({tag, i == 0 ? "/omni err" : "/ch1 err"}, {7'd0, err_o[i]}, {7'd0, exp_err});
      chk({tag, i == 0 ? "/omni cmd" : "/ch1 cmd"}, {5'd0, cmd_o[i]}, {5'd0, exp_cmd[i]});
      chk({tag, i == 0 ? "/omni ch" : "/ch1 ch"}, {4'd0, ch_o[i]}, {4'd0, exp_ch[i]});
      chk({tag, i == 0 ? "/omni d0" : "/ch1 d0"}, {1'b0, d0_o[i]}, {1'b0, exp_d0[i]});
      chk({tag, i == 0 ? "/omni d1" : "/ch1 d1"}, {1'b0, d1_o[i]}, {1'b0, exp_d1[i]});
    end
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    @(negedge clk);
    byte_rdy = 1'b1; byte_data = b;
    @(negedge clk);
    byte_rdy = 1'b0;
    model_byte(b);
    check_bus(tag);
    @(negedge clk);
    exp_rdy[0] = 1'b0; exp_rdy[1] = 1'b0; exp_err = 1'b0;
    check_bus({tag, "+1"});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_bus(tag);
  endtask

  initial begin
    logic [7:0] b;
    int cls;
    reset = 1'b0; byte_rdy = 1'b0; byte_data = 8'h00;
    model_reset();
    #2 reset = 1'b1;
    do_reset("reset");

    send("noteon", 8'h90); send("noteon", 8'h3C); send("noteon", 8'h64);
    send("run", 8'h92); send("run", 8'h40); send("run", 8'h7F);
    send("run", 8'h41); send("run", 8'h00);
    send("prog", 8'hC5); send("prog", 8'h07); send("prog", 8'h08);
    send("rt", 8'h90); send("rt", 8'h3C); send("rt", 8'hF8);
    send("rt", 8'hFE); send("rt", 8'h64);
    send("abandon", 8'h90); send("abandon", 8'h3C); send("abandon", 8'h80);
    send("abandon", 8'h40); send("abandon", 8'h00);
    send("ch1", 8'h91); send("ch1", 8'h3C); send("ch1", 8'h64);
    send("undef", 8'hF4); send("undef", 8'h12); send("undef", 8'hF9);
    send("undef", 8'hFD); send("undef", 8'hF5); send("undef", 8'h34);

    do_reset("reset2");
    send("idle_data", 8'h3C);
    send("sysex", 8'hF0); send("sysex", 8'h01); send("sysex", 8'h02);
    send("sysex", 8'hF7); send("sysex", 8'h3C);
    send("mid", 8'h90);
    do_reset("reset3");
    send("mid", 8'h3C); send("mid", 8'h64);

    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(99);
      if (cls < 50)      b = 8'($urandom_range(8'h7F));
      else if (cls < 75) b = 8'($urandom_range(8'hEF, 8'h80));
      else if (cls < 85) b = 8'($urandom_range(8'hFF, 8'hF8));
      else if (cls < 92) b = 8'hF0;
      else if (cls < 96) b = 8'hF7;
      else               b = 8'($urandom_range(8'hF6, 8'hF1));
      send("rand", b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
